// File: rtl/timex_mb_pkg.sv
// Shared types and constants for the mainboard ROM sequencer.
package timex_mb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_BOOT = 1'b1
  } gnt_t;

  localparam logic [7:0] ROM_OOR_DATA = 8'hFF;

  function automatic gnt_t other_gnt(input gnt_t g);
    return (g == GNT_CPU) ? GNT_BOOT : GNT_CPU;
  endfunction

endpackage

// File: rtl/rom_seq_arb.sv
// Two-requester round-robin arbiter; the grant is only honoured while i_en is high.
module rom_seq_arb
  import timex_mb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_cpu,
  input  logic i_req_boot,
  output logic o_gnt_vld,
  output logic o_gnt_boot
);

  gnt_t r_last_grant;
  gnt_t w_gnt;

  // On contention the side that was not served last wins.
  always_comb begin
    w_gnt = GNT_CPU;
    if (i_req_cpu && i_req_boot) begin
      w_gnt = other_gnt(r_last_grant);
    end else if (i_req_boot) begin
      w_gnt = GNT_BOOT;
    end
  end

  assign o_gnt_vld  = i_en && (i_req_cpu || i_req_boot);
  assign o_gnt_boot = (w_gnt == GNT_BOOT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GNT_BOOT;
    end else if (o_gnt_vld) begin
      r_last_grant <= w_gnt;
    end
  end

endmodule

// File: rtl/rom_seq_ctrl.sv
// ROM port sequencer shared by CPU byte reads and the boot streamer.
// Optional ROM_SEQ_CHECKSUM_EN builds the streamed-byte checksum on boot_sum.
module rom_seq_ctrl
  import timex_mb_pkg::*;
#(
  parameter int ROM_DEPTH   = 101,
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [7:0]        cpu_data,
  input  logic              boot_start,
  output logic              boot_busy,
  output logic              boot_valid,
  output logic [7:0]        boot_data,
  input  logic              boot_ready,
  output logic              boot_done,
  output logic [7:0]        boot_sum,
  output logic              rom_cs_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data
);

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [2:0]        WAIT_LAST = 3'(WAIT_CYCLES);

  state_t            r_state, w_next;
  gnt_t              r_owner;
  logic [2:0]        r_wcnt;
  logic              r_cs_n;
  logic [ADDR_W-1:0] r_addr;
  logic              r_cpu_ack;
  logic [7:0]        r_cpu_data;
  logic              r_boot_busy;
  logic              r_boot_valid;
  logic [7:0]        r_boot_data;
  logic              r_boot_done;
  logic [ADDR_W-1:0] r_boot_idx;

  logic w_cpu_in_range, w_boot_req, w_arb_en, w_gnt_vld, w_gnt_boot;
  logic w_start_access, w_oor_ack, w_capture, w_boot_xfer, w_boot_go;

  assign w_cpu_in_range = ({1'b0, cpu_addr} < DEPTH_X);
  assign w_boot_req     = r_boot_busy && !r_boot_valid && ({1'b0, r_boot_idx} < DEPTH_X);
  assign w_arb_en       = (r_state == IDLE);
  assign w_boot_xfer    = r_boot_valid && boot_ready;
  assign w_boot_go      = boot_start && !r_boot_busy;

  rom_seq_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_arb_en),
    .i_req_cpu  (cpu_req),
    .i_req_boot (w_boot_req),
    .o_gnt_vld  (w_gnt_vld),
    .o_gnt_boot (w_gnt_boot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Out-of-range CPU reads skip ACCESS but still spend a CAPTURE cycle,
  // so the CPU has time to drop its request before the next arbitration.
  always_comb begin
    w_next         = r_state;
    w_start_access = 1'b0;
    w_oor_ack      = 1'b0;
    w_capture      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          if (!w_gnt_boot && !w_cpu_in_range) begin
            w_oor_ack = 1'b1;
            w_next    = CAPTURE;
          end else begin
            w_start_access = 1'b1;
            w_next         = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (r_wcnt == WAIT_LAST) begin
          w_capture = 1'b1;
          w_next    = CAPTURE;
        end
      end
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= GNT_BOOT;
      r_wcnt  <= 3'd0;
      r_cs_n  <= 1'b1;
      r_addr  <= '0;
    end else if (w_start_access) begin
      r_owner <= w_gnt_boot ? GNT_BOOT : GNT_CPU;
      r_addr  <= w_gnt_boot ? r_boot_idx : cpu_addr;
      r_cs_n  <= 1'b0;
      r_wcnt  <= 3'd0;
    end else if (w_capture) begin
      r_cs_n <= 1'b1;
    end else if (r_state == ACCESS) begin
      r_wcnt <= r_wcnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_ack  <= 1'b0;
      r_cpu_data <= 8'h00;
    end else begin
      r_cpu_ack <= 1'b0;
      if (w_oor_ack) begin
        r_cpu_ack  <= 1'b1;
        r_cpu_data <= ROM_OOR_DATA;
      end else if (w_capture && (r_owner == GNT_CPU)) begin
        r_cpu_ack  <= 1'b1;
        r_cpu_data <= rom_data;
      end
    end
  end

  // The output register lets CPU reads proceed while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_boot_busy  <= 1'b0;
      r_boot_valid <= 1'b0;
      r_boot_data  <= 8'h00;
      r_boot_done  <= 1'b0;
      r_boot_idx   <= '0;
    end else begin
      r_boot_done <= 1'b0;
      if (w_boot_go) begin
        r_boot_busy <= 1'b1;
        r_boot_idx  <= '0;
      end
      if (w_capture && (r_owner == GNT_BOOT)) begin
        r_boot_valid <= 1'b1;
        r_boot_data  <= rom_data;
      end else if (w_boot_xfer) begin
        r_boot_valid <= 1'b0;
        r_boot_idx   <= r_boot_idx + ADDR_W'(1);
        if (r_boot_idx == LAST_IDX) begin
          r_boot_done <= 1'b1;
          r_boot_busy <= 1'b0;
        end
      end
    end
  end

`ifdef ROM_SEQ_CHECKSUM_EN
  logic [7:0] r_boot_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_boot_sum <= 8'h00;
    end else if (w_boot_go) begin
      r_boot_sum <= 8'h00;
    end else if (w_boot_xfer) begin
      r_boot_sum <= r_boot_sum + r_boot_data;
    end
  end

  assign boot_sum = r_boot_sum;
`else
  assign boot_sum = 8'h00;
`endif

  assign cpu_ack    = r_cpu_ack;
  assign cpu_data   = r_cpu_data;
  assign boot_busy  = r_boot_busy;
  assign boot_valid = r_boot_valid;
  assign boot_data  = r_boot_data;
  assign boot_done  = r_boot_done;
  assign rom_cs_n   = r_cs_n;
  assign rom_addr   = r_addr;

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Randomized bench for rom_seq_ctrl against a transaction-level ROM/stream model.
module tb_rom_seq_ctrl;

  localparam int DEPTH = 101;
  localparam int WAIT  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0;
  logic [6:0] cpu_addr = 7'd0;
  logic       cpu_ack;
  logic [7:0] cpu_data;
  logic       boot_start = 1'b0;
  logic       boot_busy, boot_valid, boot_done;
  logic [7:0] boot_data, boot_sum;
  logic       boot_ready = 1'b0;
  logic       rom_cs_n;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;

  logic [7:0] rom [0:127];

  int n_checks = 0;
  int n_errors = 0;

  int         m_idx = 0;
  logic [7:0] m_sum = 8'h00;
  int         done_cnt = 0;
  int         run = 0;
  logic [6:0] run_addr = 7'd0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         prev_valid = 1'b0;
  bit         alt_on = 1'b0;
  bit         alt_have = 1'b0;
  bit         alt_prev = 1'b0;
  int         n_alt_c = 0;
  int         n_alt_b = 0;

  rom_seq_ctrl #(.ROM_DEPTH(DEPTH), .ADDR_W(7), .WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ack    (cpu_ack),
    .cpu_data   (cpu_data),
    .boot_start (boot_start),
    .boot_busy  (boot_busy),
    .boot_valid (boot_valid),
    .boot_data  (boot_data),
    .boot_ready (boot_ready),
    .boot_done  (boot_done),
    .boot_sum   (boot_sum),
    .rom_cs_n   (rom_cs_n),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data)
  );

  always #5 clk = ~clk;

  // Asynchronous ROM; garbage whenever it is not selected.
  assign rom_data = (!rom_cs_n && (rom_addr < 7'd101)) ? rom[rom_addr] : 8'hA5;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_cpu(input logic [6:0] a);
    return (a < 7'd101) ? rom[a] : 8'hFF;
  endfunction

  function automatic logic [7:0] exp_sum();
`ifdef ROM_SEQ_CHECKSUM_EN
    return m_sum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic start_boot();
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
  endtask

  task automatic cpu_read(input logic [6:0] a, input bit chk_lat);
    int n, low;
    bit got;
    logic [7:0] d;
    n = 0; low = 0; got = 1'b0; d = 8'h00;
    cpu_addr = a;
    cpu_req  = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      tick();
      n++;
      if (!rom_cs_n) low++;
      if (cpu_ack) begin
        got = 1'b1;
        d = cpu_data;
        cpu_req = 1'b0;
      end
    end
    if (!got) begin
      cpu_req = 1'b0;
      check_val("cpu_ack_timeout", 32'd0, 32'd1);
    end else begin
      check_val("cpu_data", d, exp_cpu(a));
      if (chk_lat) begin
        check_val("cpu_latency", n, (a < 7'd101) ? WAIT + 2 : 1);
        check_val("cpu_cs_low", low, (a < 7'd101) ? WAIT + 1 : 0);
      end
    end
    tick();
  endtask

  task automatic wait_done(input int base);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 6000 && !seen; k++) begin
      tick();
      if (done_cnt != base) seen = 1'b1;
    end
    if (!seen) check_val("done_timeout", 32'd0, 32'd1);
    repeat (3) tick();
  endtask

  // Transaction monitor: ROM strobe shape, stream order, stall hold, done, grants.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      m_idx = 0;
      m_sum = 8'h00;
      run = 0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (!rom_cs_n) begin
        run++;
        if (run == 1) run_addr = rom_addr;
        else check_val("rom_addr_stable", rom_addr, run_addr);
      end else if (run != 0) begin
        check_val("cs_low_len", run, WAIT + 1);
        run = 0;
      end
      if (boot_valid && prev_stall) check_val("boot_hold", boot_data, prev_data);
      prev_stall = boot_valid && !boot_ready;
      prev_data  = boot_data;
      if (boot_start && !boot_busy) begin
        m_idx = 0;
        m_sum = 8'h00;
      end
      if (boot_valid && boot_ready) begin
        if (m_idx >= DEPTH) check_val("boot_overrun", m_idx, DEPTH - 1);
        else check_val("boot_byte", boot_data, rom[m_idx]);
        m_sum = m_sum + boot_data;
        m_idx++;
      end
      if (boot_done) begin
        done_cnt++;
        check_val("done_count", m_idx, DEPTH);
        check_val("done_busy", boot_busy, 1'b0);
        check_val("done_sum", boot_sum, exp_sum());
      end
      if (alt_on && (cpu_ack || (boot_valid && !prev_valid))) begin
        if (alt_have) check_val("grant_alternate", boot_valid && !prev_valid, !alt_prev);
        alt_prev = boot_valid && !prev_valid;
        alt_have = 1'b1;
        if (cpu_ack) n_alt_c++;
        else n_alt_b++;
      end
      prev_valid = boot_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    logic [6:0] a;
    int base;
    bit seen;

    for (int i = 0; i < 128; i++) rom[i] = 8'((i * 73 + 18) ^ (i >> 3));
    rom[0]   = 8'h12;
    rom[5]   = 8'hBC;
    rom[100] = 8'h00;
    s = 8'h00;
    for (int i = 0; i < DEPTH; i++) if (i != 77) s = s + rom[i];
    rom[77] = 8'h45 - s;

    // Reset state
    repeat (3) tick();
    check_val("rst_cpu_ack", cpu_ack, 1'b0);
    check_val("rst_boot_busy", boot_busy, 1'b0);
    check_val("rst_boot_valid", boot_valid, 1'b0);
    check_val("rst_boot_done", boot_done, 1'b0);
    check_val("rst_cpu_data", cpu_data, 8'h00);
    check_val("rst_boot_data", boot_data, 8'h00);
    check_val("rst_boot_sum", boot_sum, 8'h00);
    check_val("rst_cs_n", rom_cs_n, 1'b1);
    check_val("rst_rom_addr", rom_addr, 7'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Isolated CPU reads, including the range boundary
    cpu_read(7'd5, 1'b1);
    cpu_read(7'd100, 1'b1);
    cpu_read(7'd101, 1'b1);
    for (int i = 0; i < 10; i++) begin
      a = 7'($urandom_range(0, 127));
      cpu_read(a, 1'b1);
    end

    // Full stream with the sink always ready
    boot_ready = 1'b1;
    base = done_cnt;
    start_boot();
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (boot_valid) begin
        seen = 1'b1;
        check_val("first_byte", boot_data, 8'h12);
      end else begin
        tick();
      end
    end
    if (!seen) check_val("first_byte_timeout", 32'd0, 32'd1);
    wait_done(base);
    check_val("done_pulses", done_cnt - base, 1);
    check_val("busy_after_done", boot_busy, 1'b0);
`ifdef ROM_SEQ_CHECKSUM_EN
    check_val("image_sum", boot_sum, 8'h45);
`endif

    // Stalled sink: CPU still served, output byte held
    boot_ready = 1'b0;
    base = done_cnt;
    start_boot();
    cpu_read(7'd0, 1'b0);
    repeat (8) tick();
    check_val("stall_valid", boot_valid, 1'b1);
    check_val("stall_data", boot_data, 8'h12);
    start_boot();
    fork
      begin
        for (int k = 0; k < 6000 && done_cnt == base; k++) begin
          boot_ready = 1'($urandom_range(0, 1));
          tick();
        end
        boot_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) cpu_read(7'($urandom_range(0, 127)), 1'b0);
      end
    join
    wait_done(base);
    check_val("rand_done_pulses", done_cnt - base, 1);

    // Contention: CPU and boot both requesting back to back
    boot_ready = 1'b1;
    base = done_cnt;
    start_boot();
    alt_have = 1'b0;
    n_alt_c = 0;
    n_alt_b = 0;
    alt_on = 1'b1;
    for (int i = 0; i < 10; i++) cpu_read(7'($urandom_range(0, 100)), 1'b0);
    alt_on = 1'b0;
    check_val("alt_cpu_grants", n_alt_c, 10);
    check_val("alt_boot_grants", (n_alt_b >= 9) ? 1 : 0, 1);
    wait_done(base);

    // Reset during the 50th byte's access
    base = done_cnt;
    start_boot();
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      tick();
      if (m_idx == 49 && !rom_cs_n) seen = 1'b1;
    end
    if (!seen) check_val("byte50_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    tick();
    check_val("abort_cs_n", rom_cs_n, 1'b1);
    check_val("abort_busy", boot_busy, 1'b0);
    check_val("abort_sum", boot_sum, 8'h00);
    check_val("abort_valid", boot_valid, 1'b0);
    rst = 1'b0;
    repeat (20) tick();
    check_val("abort_no_done", done_cnt - base, 0);
    check_val("abort_idle_cs", rom_cs_n, 1'b1);
    start_boot();
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (!rom_cs_n) begin
        seen = 1'b1;
        check_val("restart_addr", rom_addr, 7'd0);
      end else begin
        tick();
      end
    end
    if (!seen) check_val("restart_timeout", 32'd0, 32'd1);
    wait_done(base);
    check_val("restart_done_pulses", done_cnt - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rom_seq_ctrl.md
# rom_seq_ctrl

Sequencer and arbiter for the mainboard CPLD's 101-byte character/config ROM (active-low `cs`, 7-bit address, 8-bit data). It shares the single ROM port between host CPU byte reads and an internal boot streamer. The boot streamer copies the whole ROM out over a valid/ready byte interface at startup. All ROM strobing, wait-state timing and out-of-range protection are owned here.

## Interface
- `ROM_DEPTH`, 101: number of valid ROM bytes (addresses 0..ROM_DEPTH-1).
- `ADDR_W`, 7: ROM address width.
- `WAIT_CYCLES`, 2: extra cycles `rom_cs_n` is held low before data capture (0..7).
- `clk  in  1`: single clock.
- `rst  in  1`: synchronous, active-high reset.
- `cpu_req  in  1`: level request; held until `cpu_ack`.
- `cpu_addr  in  ADDR_W`: byte address, stable while `cpu_req` is high.
- `cpu_ack  out  1`: one-cycle pulse; `cpu_data` valid in the same cycle.
- `cpu_data  out  8`: read data, held until the next ack.
- `boot_start  in  1`: pulse; starts a full-ROM stream.
- `boot_busy  out  1`: stream in progress.
- `boot_valid  out  1`: `boot_data` is valid.
- `boot_data  out  8`: streamed byte.
- `boot_ready  in  1`: sink accepts the byte when `boot_valid & boot_ready`.
- `boot_done  out  1`: one-cycle pulse after the last byte is accepted.
- `boot_sum  out  8`: streamed checksum (see Configuration).
- `rom_cs_n  out  1`: ROM chip select, active low.
- `rom_addr  out  ADDR_W`: ROM address.
- `rom_data  in  8`: ROM data.

## Operation
- FSM states:
  - IDLE → ACCESS: on a grant.
  - ACCESS (`rom_cs_n`=0, wait counter running) → CAPTURE.
  - CAPTURE → IDLE.
- Requesters are the CPU (`cpu_req`) and the boot fetcher. The boot fetcher requests only when `boot_busy` is set, its output register is empty, and its index is below ROM_DEPTH.
- Arbitration is evaluated only in IDLE, using a `last_grant` bit:
  - If both request, the one not granted last wins.
  - A lone requester always wins.
  - An access in progress is never preempted.
- Out-of-range CPU address (≥ ROM_DEPTH): no ACCESS state and `rom_cs_n` stays 1. `cpu_ack` pulses the cycle after the grant with `cpu_data`=0xFF.
- `rom_addr` is driven only during ACCESS; otherwise it holds its last value.
- Boot stream:
  - `boot_start` while idle clears the index and `boot_sum`, and sets `boot_busy`.
  - `boot_start` while busy is ignored.
  - Each fetched byte loads the output register and sets `boot_valid`.
  - On `boot_valid & boot_ready`: clear `boot_valid` and increment the index.
  - When the byte at index ROM_DEPTH-1 is accepted: `boot_done` pulses for one cycle and `boot_busy` clears in the same cycle.
- CPU reads are served while the boot sink stalls, because the output register decouples the ROM from the sink.
- Reset mid-operation: the stream is aborted, no `boot_done` is generated, and `rom_cs_n` returns high on the next edge.

## Timing
- Reset values:
  - `cpu_ack`, `boot_busy`, `boot_valid`, `boot_done` = 0.
  - `cpu_data`, `boot_data`, `boot_sum` = 0x00.
  - `rom_cs_n` = 1, `rom_addr` = 0, `last_grant` = boot.
- In-range access: a grant at edge N produces ACCESS for WAIT_CYCLES+1 cycles, starting at N+1.
  - `rom_data` is registered at the edge that ends the last ACCESS cycle.
  - CAPTURE follows for one cycle, carrying `cpu_ack` (CPU access) or `boot_valid` rising (boot access).
  - WAIT_CYCLES=2: request sampled at edge 0, `rom_cs_n` low for cycles 1–3, ack in cycle 4.
- CPU must drop `cpu_req` in the cycle after `cpu_ack`. A request still high in the following IDLE cycle is a new read.
- `boot_data` is stable while `boot_valid` is high and `boot_ready` is low.
- Minimum spacing between ROM accesses is one IDLE cycle.

## Configuration
- `ROM_SEQ_CHECKSUM_EN` defined:
  - `boot_sum` accumulates the modulo-256 sum of each byte at its valid/ready handshake.
  - The final value is valid from `boot_done` until the next `boot_start`.
- `ROM_SEQ_CHECKSUM_EN` undefined: `boot_sum` is tied to 0x00 and no adder is built.

## Structure
- Package `timex_mb_pkg` holds:
  - The FSM state enum (IDLE, ACCESS, CAPTURE).
  - The grant enum (GNT_CPU, GNT_BOOT).
  - The constant `ROM_OOR_DATA` = 8'hFF.
- One sub-module, `rom_seq_arb`: two-requester round-robin arbiter with the `last_grant` register and a grant-valid output.

## Test plan
- ROM model loaded with the production image, WAIT_CYCLES=2.
- CPU read of address 5: `rom_cs_n` low for exactly 3 cycles, ack 4 cycles after the request, `cpu_data`=0xBC.
- CPU read of address 100 returns 0x00. CPU read of address 101 returns 0xFF with `rom_cs_n` never low.
- `boot_start` with `boot_ready` tied high:
  - 101 bytes stream in order, the first being 0x12.
  - `boot_done` pulses once.
  - With the macro defined, `boot_sum`=0x45.
- Boot with `boot_ready` low and `cpu_req` asserted for address 0: the CPU gets `cpu_data`=0x12, and `boot_data` holds 0x12 until ready.
- Simultaneous CPU and boot requests for 20 cycles: grants strictly alternate and neither side starves.
- `rst` asserted during the 50th streamed byte's ACCESS state:
  - Next cycle: `rom_cs_n`=1, `boot_busy`=0, `boot_sum`=0.
  - No `boot_done`.
  - A new `boot_start` restarts from address 0.
